// File: rtl/mul29_pp_sequencer.sv
// Partial-product sequencer: latches one operand pair, streams each column's
// partial-product bits into the external column shift registers, waits out
// the compressor pipeline and captures the compressor result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b are the operands
//   col_bit[NC-1:0]      serial input for each column shift register
//   dst_bits[OUT_W-1:0]  compressor result vector
//   out_valid/out_ready  result handshake; out_data is the captured result
//   busy                 high while an operation is in flight
module mul29_pp_sequencer #(
    parameter int W       = 29,
    parameter int CAP_DLY = 0,
    parameter int OUT_W   = 2*W+1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    output logic [2*W-2:0]    col_bit,
    input  logic [OUT_W-1:0]  dst_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    localparam int NC = 2*W-1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = (CAP_DLY > 0) ? $clog2(CAP_DLY+1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      step_q, step_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               ov_q, ov_d;
    logic [OUT_W-1:0]   od_q, od_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ov_d    = ov_q;
        od_d    = od_q;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                // No bypass: a pending result blocks the next accept.
                if (in_valid && !ov_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    step_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                step_d = step_q + IW'(1);
                if (step_q == IW'(W-1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // With no pipeline this samples dst before zeros shift in.
                if (cnt_q == CW'(CAP_DLY)) begin
                    od_d    = dst_bits;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Column k of height h gets its h bits on the last h load steps, so
    // after W shifts the register holds exactly those bits.
    for (genvar k = 0; k < NC; k++) begin : g_col
        localparam int H    = (k + 1 < NC - k) ? k + 1 : NC - k;
        localparam int OFF  = W - H;
        localparam int JMIN = (k >= W) ? k - W + 1 : 0;

        logic [IW-1:0] t;
        logic [IW-1:0] ai;
        logic [IW-1:0] bi;

        assign t  = step_q - IW'(OFF);
        assign ai = IW'(JMIN) + t;
        assign bi = IW'(k - JMIN) - t;

        assign col_bit[k] = (state_q == LOAD)
                         && (step_q >= IW'(OFF))
                         && a_q[ai]
                         && b_q[bi];
    end

    assign in_ready  = (state_q == IDLE) && !ov_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul29_pp_sequencer.sv
// Bench for mul29_pp_sequencer with a behavioural column shift-register and
// combinational compressor datapath; expected products computed as a*b.
module tb_mul29_pp_sequencer;

    localparam int W       = 29;
    localparam int CAP_DLY = 0;
    localparam int OUT_W   = 2*W+1;
    localparam int NC      = 2*W-1;
    localparam int LAT     = W + CAP_DLY + 1;
    // accept -> result (LAT) -> one cycle holding out_valid -> next accept
    localparam int SPACING = LAT + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [NC-1:0]    col_bit;
    logic [OUT_W-1:0] dst_bits;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mul29_pp_sequencer #(
        .W(W), .CAP_DLY(CAP_DLY), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .col_bit(col_bit), .dst_bits(dst_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: column k is a shift register of height h_k.
    logic [W-1:0] colreg [NC];

    function automatic int col_h(input int k);
        return (k + 1 < NC - k) ? k + 1 : NC - k;
    endfunction

    initial begin
        for (int k = 0; k < NC; k++) colreg[k] = '0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < NC; k++)
            colreg[k] <= {colreg[k][W-2:0], col_bit[k]};
    end

    always_comb begin
        dst_bits = '0;
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < col_h(k); j++)
                dst_bits = dst_bits + (OUT_W'(colreg[k][j]) << k);
    end

    function automatic logic [OUT_W-1:0] prod(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        return OUT_W'(a) * OUT_W'(b);
    endfunction

    // Offer a pair and return #1 after the accepting edge (LOAD step 0).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit keep_valid, output bit seen);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        seen = (in_ready === 1'b1);
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            $display("FAIL reset_ctl: rdy/busy/ov=%b required 100",
                     {in_ready, busy, out_valid});
            n_fail++;
        end
        n_checks++;
        if (out_data !== '0 || col_bit !== '0) begin
            $display("FAIL reset_data: out_data=%h col_bit=%h required 0",
                     out_data, col_bit);
            n_fail++;
        end
    endtask

    task automatic test_small;
        bit seen;
        int n;
        int bad;
        start_op(29'd3, 29'd5, 1'b0, seen);
        n_checks++;
        if (!seen) begin
            $display("FAIL small_accept: in_ready never 1");
            n_fail++;
        end
        n   = 0;
        bad = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL small_ready: %0d cycles ready/idle, required 0", bad);
            n_fail++;
        end
        n_checks++;
        if (n != LAT) begin
            $display("FAIL small_latency: %0d edges required %0d", n, LAT);
            n_fail++;
        end
        n_checks++;
        if (out_data !== prod(29'd3, 29'd5)) begin
            $display("FAIL small_data: %h required %h", out_data, 59'd15);
            n_fail++;
        end
    endtask

    task automatic test_max;
        bit seen;
        int n;
        int bad28;
        int bad0;
        logic [W-1:0] m;
        m = '1;
        start_op(m, m, 1'b0, seen);
        bad28 = 0;
        bad0  = 0;
        for (int s = 0; s < W; s++) begin
            if (col_bit[W-1] !== 1'b1) bad28++;
            if (col_bit[0] !== (s == W-1)) bad0++;
            @(posedge clk); #1;
        end
        wait_out(n);
        n_checks++;
        if (bad28 != 0 || bad0 != 0) begin
            $display("FAIL max_cols: col28 bad=%0d col0 bad=%0d required 0",
                     bad28, bad0);
            n_fail++;
        end
        n_checks++;
        if (W + n != LAT) begin
            $display("FAIL max_latency: %0d edges required %0d", W + n, LAT);
            n_fail++;
        end
        n_checks++;
        if (out_data !== 59'h3FFFFFFC0000001) begin
            $display("FAIL max_data: %h required %h",
                     out_data, 59'h3FFFFFFC0000001);
            n_fail++;
        end
    endtask

    task automatic test_zero;
        bit seen;
        int n;
        int bad;
        start_op(29'd0, 29'h1ABCDEF, 1'b0, seen);
        n   = 0;
        bad = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (col_bit !== '0) bad++;
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (bad != 0 || n != LAT - 0) begin
            $display("FAIL zero_cols: nonzero=%0d lat=%0d required 0/%0d",
                     bad, n, LAT);
            n_fail++;
        end
        n_checks++;
        if (out_data !== '0) begin
            $display("FAIL zero_data: %h required 0", out_data);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit seen;
        int n;
        int last;
        int bad_sp;
        int bad_d;
        out_ready = 1'b1;
        bad_sp    = 0;
        bad_d     = 0;
        last      = 0;
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            start_op(a, b, 1'b1, seen);
            if (!seen) bad_sp++;
            if (i > 0 && cyc - last != SPACING) begin
                bad_sp++;
                $display("FAIL b2b_spacing: op %0d spacing %0d required %0d",
                         i, cyc - last, SPACING);
            end
            last = cyc;
            in_a = W'($urandom);
            in_b = W'($urandom);
            wait_out(n);
            if (n != LAT || out_data !== prod(a, b)) begin
                bad_d++;
                $display("FAIL b2b_data: op %0d data %h lat %0d required %h/%0d",
                         i, out_data, n, prod(a, b), LAT);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad_sp != 0) n_fail++;
        n_checks++;
        if (bad_d != 0) n_fail++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit seen;
        int n;
        int bad;
        out_ready = 1'b0;
        start_op(29'd11, 29'd13, 1'b0, seen);
        wait_out(n);
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 59'd143 || in_ready !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d bad cycles required 0", bad);
            n_fail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 59'd143) begin
            $display("FAIL bp_release: rdy=%b ov=%b data=%h required 1/0/%h",
                     in_ready, out_valid, out_data, 59'd143);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        int n;
        int bad;
        start_op(29'd123, 29'd456, 1'b0, seen);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || col_bit !== '0) begin
            $display("FAIL rst_mid: busy=%b ov=%b col=%h required 0/0/0",
                     busy, out_valid, col_bit);
            n_fail++;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || out_data !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL rst_abort: %0d cycles with output, required 0", bad);
            n_fail++;
        end
        start_op(29'd7, 29'd9, 1'b0, seen);
        wait_out(n);
        n_checks++;
        if (n != LAT || out_data !== 59'd63) begin
            $display("FAIL rst_next: data=%h lat=%0d required %h/%0d",
                     out_data, n, 59'd63, LAT);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_max();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
